apu_mixer: RTL and testbench

Sample-based mixer between the four APU channel generators and the PWM audio converter. On each sample strobe it snapshots the four 4-bit channel levels, accumulates the enabled channels serially through one adder, applies a 3-bit master volume, and presents a 6-bit mixed sample with a valid/ready hold to the downstream PWM stage. It replaces the combinational channel sum feeding the mixed PWM output.

---
 rtl/apu_mixer.sv | 175 +++++++++++++++++
 tb/tb_apu_mixer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/apu_mixer.sv
// apu_mixer: snapshots four 4-bit APU channel levels on a sample strobe and
// sums the enabled ones serially through a single adder. The sum is scaled by
// a 3-bit master volume and the 6-bit result is held with a valid/ready
// handshake for the PWM stage.
// Optional feature macro: APU_MIXER_HPF_EN adds a first-order DC blocker
// that re-centres the output around 32.
module apu_mixer #(
  parameter int HPF_SHIFT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_strobe,
  input  logic [3:0] ch1,
  input  logic [3:0] ch2,
  input  logic [3:0] ch3,
  input  logic [3:0] ch4,
  input  logic [3:0] ch_enable,
  input  logic [2:0] master_vol,
  input  logic       mute,
  input  logic       out_ready,
  output logic [5:0] audio_out,
  output logic       out_valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, ACC, SCALE, HOLD} state_t;

`ifdef APU_MIXER_HPF_EN
  localparam logic [5:0] AUDIO_RST = 6'd32;
  localparam int         CW        = 6 + HPF_SHIFT;

  // Saturate the re-centred filter output into the unsigned 6-bit range.
  function automatic logic [5:0] clamp6(input logic signed [7:0] v);
    if (v < 8'sd0)       clamp6 = 6'd0;
    else if (v > 8'sd63) clamp6 = 6'd63;
    else                 clamp6 = v[5:0];
  endfunction

  logic [CW-1:0]      cap_acc_q, cap_acc_d;
  logic [5:0]         cap_int;
  logic signed [7:0]  hpf_val;
`else
  localparam logic [5:0] AUDIO_RST = 6'd0;
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [5:0]  acc_q, acc_d;
  logic [15:0] sh_ch_q, sh_ch_d;
  logic [3:0]  sh_en_q, sh_en_d;
  logic [2:0]  sh_vol_q, sh_vol_d;
  logic        sh_mute_q, sh_mute_d;
  logic [5:0]  audio_q, audio_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic [3:0]  cur_ch;
  logic [3:0]  addend;
  logic [3:0]  vol_p1;
  logic [8:0]  product;
  logic [5:0]  scaled;

  // Next-state and datapath: serial accumulate, scale, then hold for handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sh_ch_d   = sh_ch_q;
    sh_en_d   = sh_en_q;
    sh_vol_d  = sh_vol_q;
    sh_mute_d = sh_mute_q;
    audio_d   = audio_q;
    valid_d   = valid_q;

    cur_ch  = sh_ch_q[{idx_q, 2'b00} +: 4];
    addend  = sh_en_q[idx_q] ? cur_ch : 4'd0;
    vol_p1  = {1'b0, sh_vol_q} + 4'd1;
    product = {3'b000, acc_q} * {5'b00000, vol_p1};
    scaled  = product[8:3];

`ifdef APU_MIXER_HPF_EN
    cap_acc_d = cap_acc_q;
    cap_int   = cap_acc_q[CW-1 -: 6];
    hpf_val   = 8'sd32 + $signed({2'b00, scaled}) - $signed({2'b00, cap_int});
`endif

    // Any strobe outside IDLE, including the handshake cycle, is dropped.
    overrun_d = overrun_q | (sample_strobe && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          sh_ch_d   = {ch4, ch3, ch2, ch1};
          sh_en_d   = ch_enable;
          sh_vol_d  = master_vol;
          sh_mute_d = mute;
          acc_d     = 6'd0;
          idx_d     = 2'd0;
          state_d   = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + {2'b00, addend};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = SCALE;
      end
      SCALE: begin
`ifdef APU_MIXER_HPF_EN
        if (sh_mute_q) begin
          audio_d = 6'd32;
        end else begin
          audio_d   = clamp6(hpf_val);
          cap_acc_d = cap_acc_q + CW'(scaled) - CW'(cap_int);
        end
`else
        audio_d = sh_mute_q ? 6'd0 : scaled;
`endif
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register; reset abandons any sample in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      acc_q     <= 6'd0;
      sh_ch_q   <= 16'd0;
      sh_en_q   <= 4'd0;
      sh_vol_q  <= 3'd0;
      sh_mute_q <= 1'b0;
      audio_q   <= AUDIO_RST;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef APU_MIXER_HPF_EN
      cap_acc_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sh_ch_q   <= sh_ch_d;
      sh_en_q   <= sh_en_d;
      sh_vol_q  <= sh_vol_d;
      sh_mute_q <= sh_mute_d;
      audio_q   <= audio_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef APU_MIXER_HPF_EN
      cap_acc_q <= cap_acc_d;
`endif
    end
  end

  assign audio_out = audio_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_apu_mixer.sv
// Directed bench for apu_mixer: hand-computed expected samples, timing of
// valid/busy, backpressure, overrun, mute and asynchronous reset.
module tb_apu_mixer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_strobe = 1'b0;
  logic [3:0] ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0;
  logic [3:0] ch_enable = '0;
  logic [2:0] master_vol = '0;
  logic       mute = 1'b0;
  logic       out_ready = 1'b1;
  logic [5:0] audio_out;
  logic       out_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

`ifdef APU_MIXER_HPF_EN
  localparam logic [5:0] RST_AUDIO = 6'd32;
`else
  localparam logic [5:0] RST_AUDIO = 6'd0;
`endif

  apu_mixer #(.HPF_SHIFT(4)) dut (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe),
    .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
    .ch_enable(ch_enable), .master_vol(master_vol), .mute(mute),
    .out_ready(out_ready), .audio_out(audio_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the strobe for exactly one edge (E0); returns just after E0.
  task automatic strobe();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic set_ch(input logic [3:0] a, b, c, d);
    ch1 = a; ch2 = b; ch3 = c; ch4 = d;
  endtask

  logic [5:0] held;
  logic       ok;
`ifdef APU_MIXER_HPF_EN
  logic [5:0] prev;
  int         first_out;
`endif

  initial begin
    #3;
    check("rst_audio", 16'(audio_out), 16'(RST_AUDIO));
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_overrun", 16'(overrun), 16'd0);
    tick();
    reset = 1'b0;
    tick();

`ifndef APU_MIXER_HPF_EN
    // Basic mix: full scale, out_ready already high.
    set_ch(4'd15, 4'd15, 4'd15, 4'd15);
    ch_enable = 4'hF; master_vol = 3'd7; out_ready = 1'b1;
    strobe();
    check("basic_busy_e0", 16'(busy), 16'd1);
    repeat (4) tick();
    check("basic_valid_e4", 16'(out_valid), 16'd0);
    tick();
    check("basic_valid_e5", 16'(out_valid), 16'd1);
    check("basic_audio", 16'(audio_out), 16'd60);
    tick();
    check("basic_valid_e6", 16'(out_valid), 16'd0);
    check("basic_busy_e6", 16'(busy), 16'd0);
    check("basic_audio_hold", 16'(audio_out), 16'd60);

    // Enable mask and volume; inputs change after capture.
    set_ch(4'd3, 4'd5, 4'd7, 4'd9);
    ch_enable = 4'b0101; master_vol = 3'd3;
    strobe();
    set_ch(4'd15, 4'd15, 4'd15, 4'd15);
    ch_enable = 4'hF; master_vol = 3'd7;
    repeat (5) tick();
    check("en_vol_valid", 16'(out_valid), 16'd1);
    check("en_vol_audio", 16'(audio_out), 16'd5);
    tick();
    check("en_vol_done", 16'(out_valid), 16'd0);

    // Mute captured at the strobe.
    mute = 1'b1;
    strobe();
    mute = 1'b0;
    repeat (5) tick();
    check("mute_valid", 16'(out_valid), 16'd1);
    check("mute_audio", 16'(audio_out), 16'd0);
    tick();

    // Backpressure with a stray strobe at E3: 60*2/8 = 15.
    out_ready = 1'b0; master_vol = 3'd1;
    strobe();
    repeat (2) tick();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("ovr_set", 16'(overrun), 16'd1);
    repeat (2) tick();
    check("bp_valid_e5", 16'(out_valid), 16'd1);
    check("bp_audio", 16'(audio_out), 16'd15);
    held = audio_out;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b1 || audio_out !== held) ok = 1'b0;
    end
    check("bp_stable", 16'(ok), 16'd1);
    out_ready = 1'b1;
    tick();
    check("bp_release", 16'(out_valid), 16'd0);
    check("ovr_sticky", 16'(overrun), 16'd1);
    tick();
    check("ovr_sticky_idle", 16'(overrun), 16'd1);

    // Asynchronous reset at E2 of a full-scale sample.
    master_vol = 3'd7;
    strobe();
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_overrun", 16'(overrun), 16'd0);
    check("mid_rst_audio", 16'(audio_out), 16'(RST_AUDIO));
    tick();
    reset = 1'b0;
    repeat (7) tick();
    check("post_rst_valid", 16'(out_valid), 16'd0);
    check("post_rst_audio", 16'(audio_out), 16'(RST_AUDIO));
`else
    // Mute gives mid-scale output.
    set_ch(4'd15, 4'd15, 4'd15, 4'd15);
    ch_enable = 4'hF; master_vol = 3'd7; mute = 1'b1;
    strobe();
    mute = 1'b0;
    repeat (5) tick();
    check("hpf_mute_audio", 16'(audio_out), 16'd32);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Constant input with scaled = 40, back-to-back samples.
    set_ch(4'd10, 4'd10, 4'd10, 4'd10);
    ok = 1'b1;
    first_out = -1;
    prev = 6'd63;
    for (int s = 0; s < 150; s++) begin
      strobe();
      repeat (5) tick();
      if (first_out < 0) first_out = int'(audio_out);
      if (audio_out > prev) ok = 1'b0;
      prev = audio_out;
      tick();
    end
    check("hpf_first", 16'(first_out), 16'd63);
    check("hpf_monotonic", 16'(ok), 16'd1);
    check("hpf_settled", 16'((prev >= 6'd31) && (prev <= 6'd33)), 16'd1);
    check("hpf_busy_end", 16'(busy), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
